decode_sequencer: RTL



---
 rtl/decode_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/decode_sequencer.sv
// Frame decode sequencer: walks block positions as IDCT blocks are accepted, then
// hands off to histogram / CDF units and counts finished frames.
module decode_sequencer #(
   parameter int IMAGE_WIDTH       = 320,
   parameter int IMAGE_HEIGHT      = 240,
   parameter int TABLE_EDGE_SIZE   = 8,
   parameter int CHANNELS          = 1,
   parameter int FRAME_COUNT_WIDTH = 16,
   localparam int BW  = IMAGE_WIDTH / TABLE_EDGE_SIZE,
   localparam int BH  = IMAGE_HEIGHT / TABLE_EDGE_SIZE,
   localparam int BWI = (BW > 1) ? $clog2(BW) : 1,
   localparam int BHI = (BH > 1) ? $clog2(BH) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         block_valid,
   output logic                         block_ready,
   input  logic [15:0]                  command,
   input  logic                         command_valid,
   input  logic                         histogram_done,
   input  logic                         cdf_done,
   output logic [1:0]                   block_channel,
   output logic [BWI-1:0]               decoded_width_block_index,
   output logic [BHI-1:0]               decoded_height_block_index,
   output logic                         image_generated,
   output logic                         histogram_generated,
   output logic                         start_CDF,
   output logic                         frame_done,
   output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
   output logic                         overrun,
   output logic                         busy
);

   localparam logic [15:0] CDF_COMMAND = 16'hA050;

   typedef enum logic [1:0] {
      DECODE    = 2'd0,
      WAIT_HIST = 2'd1,
      CDF       = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t                       state_reg, state_next;
   logic [1:0]                   chan_reg, chan_next;
   logic [BWI-1:0]               wi_reg, wi_next;
   logic [BHI-1:0]               hi_reg, hi_next;
   logic                         hist_seen_reg, hist_seen_next;
   logic [FRAME_COUNT_WIDTH-1:0] fc_reg, fc_next;
   logic                         img_reg, img_next;
   logic                         hg_reg, hg_next;
   logic                         sc_reg, sc_next;
   logic                         fd_reg, fd_next;
   logic                         ready_reg;
   logic                         busy_reg;
   logic                         overrun_reg;
   logic [15:0]                  cmd_reg;

   logic accept;
   logic last_chan, last_col, last_row;

   assign accept    = block_valid && ready_reg;
   assign last_chan = (chan_reg == 2'(CHANNELS - 1));
   assign last_col  = (wi_reg == BWI'(BW - 1));
   assign last_row  = (hi_reg == BHI'(BH - 1));

   always_comb begin
      state_next     = state_reg;
      chan_next      = chan_reg;
      wi_next        = wi_reg;
      hi_next        = hi_reg;
      hist_seen_next = hist_seen_reg;
      fc_next        = fc_reg;
      img_next       = 1'b0;
      hg_next        = 1'b0;
      sc_next        = 1'b0;
      fd_next        = 1'b0;
      case (state_reg)
         DECODE: begin
            if (histogram_done) hist_seen_next = 1'b1;
            if (accept) begin
               if (!last_chan) begin
                  chan_next = chan_reg + 2'd1;
               end else begin
                  chan_next = 2'd0;
                  if (!last_col) begin
                     wi_next = wi_reg + BWI'(1);
                  end else begin
                     wi_next = '0;
                     if (!last_row) begin
                        hi_next = hi_reg + BHI'(1);
                     end else begin
                        hi_next    = '0;
                        img_next   = 1'b1;
                        state_next = WAIT_HIST;
                     end
                  end
               end
            end
         end
         WAIT_HIST: begin
            if (hist_seen_reg || histogram_done) begin
               hg_next        = 1'b1;
               hist_seen_next = 1'b0;
               // Decision uses the command held before this cycle's strobe
               if (cmd_reg == CDF_COMMAND) begin
                  sc_next    = 1'b1;
                  state_next = CDF;
               end else begin
                  state_next = DONE;
               end
            end
         end
         CDF: begin
            if (cdf_done) state_next = DONE;
         end
         DONE: begin
            fd_next    = 1'b1;
            fc_next    = fc_reg + FRAME_COUNT_WIDTH'(1);
            state_next = DECODE;
         end
         default: state_next = DECODE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= DECODE;
         chan_reg      <= '0;
         wi_reg        <= '0;
         hi_reg        <= '0;
         hist_seen_reg <= 1'b0;
         fc_reg        <= '0;
         img_reg       <= 1'b0;
         hg_reg        <= 1'b0;
         sc_reg        <= 1'b0;
         fd_reg        <= 1'b0;
         ready_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         overrun_reg   <= 1'b0;
         cmd_reg       <= 16'h0000;
      end else begin
         state_reg     <= state_next;
         chan_reg      <= chan_next;
         wi_reg        <= wi_next;
         hi_reg        <= hi_next;
         hist_seen_reg <= hist_seen_next;
         fc_reg        <= fc_next;
         img_reg       <= img_next;
         hg_reg        <= hg_next;
         sc_reg        <= sc_next;
         fd_reg        <= fd_next;
         ready_reg     <= (state_next == DECODE);
         busy_reg      <= (state_next != DECODE);
         if (block_valid && !ready_reg) overrun_reg <= 1'b1;
         if (command_valid) cmd_reg <= command;
      end
   end

   assign block_ready                = ready_reg;
   assign block_channel              = chan_reg;
   assign decoded_width_block_index  = wi_reg;
   assign decoded_height_block_index = hi_reg;
   assign image_generated            = img_reg;
   assign histogram_generated        = hg_reg;
   assign start_CDF                  = sc_reg;
   assign frame_done                 = fd_reg;
   assign frame_count                = fc_reg;
   assign overrun                    = overrun_reg;
   assign busy                       = busy_reg;

endmodule
